// File: rtl/data_mem_responder.sv
// data_mem_responder: data-memory slave that holds the MEM stage for WAIT_STATES cycles per access,
// then completes the load/store and pulses ready (with access_err on illegal requests).
module data_mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [3:0]  byte_en,
  output logic [31:0] read_data,
  output logic        ready,
  output logic        mem_stall,
  output logic        access_err
);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_RESP = 2'd2;
  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [31:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]    be_q, be_d;
  logic          rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic [31:0]   mem_q [DEPTH_WORDS] = '{default: '0};
  logic          req, req_err, to_resp;
  assign req = mem_read | mem_write;
  assign req_err = (mem_read & mem_write) | (|addr[1:0]) | (|(addr >> (AW + 2)));
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    wdata_d = wdata_q;
    be_d = be_q;
    rd_d = rd_q;
    wr_d = wr_q;
    err_d = err_q;
    if (state_q == S_IDLE && req) begin
      idx_d = addr[AW+1:2];
      wdata_d = write_data;
      be_d = byte_en;
      rd_d = mem_read;
      wr_d = mem_write;
      err_d = req_err;
      cnt_d = 4'(WAIT_STATES);
      state_d = (WAIT_STATES > 0) ? S_WAIT : S_RESP;
    end else if (state_q == S_WAIT) begin
      cnt_d = cnt_q - 4'd1;
      state_d = (cnt_q == 4'd1) ? S_RESP : S_WAIT;
    end else if (state_q == S_RESP) begin
      state_d = S_IDLE;
    end
  end
  // read_data only changes on the edge entering RESP; idx_d/rd_d/err_d already reflect the live request
  assign to_resp = (state_d == S_RESP) && (state_q != S_RESP);
  assign rdata_d = !to_resp ? rdata_q : err_d ? '0 : rd_d ? mem_q[idx_d] : rdata_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      wdata_q <= wdata_d;
      be_q <= be_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      err_q <= err_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == S_RESP && wr_q && !err_q)
      for (int b = 0; b < 4; b++)
        if (be_q[b]) mem_q[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
  end
  assign read_data = rdata_q;
  assign ready = state_q == S_RESP;
  assign access_err = ready & err_q;
  assign mem_stall = (state_q == S_IDLE && req) || state_q == S_WAIT;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed checks of a 2-wait-state responder plus a zero-wait instance
// sharing the same request bus.
module tb_data_mem_responder;
  logic        clk = 1'b0, reset = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  logic [31:0] addr = '0, write_data = '0;
  logic [3:0]  byte_en = '0;
  logic [31:0] rdata2, rdata0;
  logic        ready2, stall2, err2, ready0, stall0, err0;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) u2 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .byte_en(byte_en), .read_data(rdata2), .ready(ready2),
    .mem_stall(stall2), .access_err(err2));
  data_mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .byte_en(byte_en), .read_data(rdata0), .ready(ready0),
    .mem_stall(stall0), .access_err(err0));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // Drives one request at a negedge with the DUT idle; checks stall at T..T+2 and the response at T+3.
  task automatic access(input logic r, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic exp_err, input logic [31:0] exp_rd,
                        input string tag);
    mem_read = r;
    mem_write = w;
    addr = a;
    write_data = wd;
    byte_en = be;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk({tag, " stall"}, stall2, 1);
      chk({tag, " early_ready"}, ready2, 0);
      @(negedge clk);
    end
    #1;
    chk({tag, " ready"}, ready2, 1);
    chk({tag, " resp_stall"}, stall2, 0);
    chk({tag, " err"}, err2, exp_err);
    chk({tag, " rdata"}, rdata2, exp_rd);
    mem_read = 1'b0;
    mem_write = 1'b0;
    @(negedge clk);
  endtask
  initial begin
    @(negedge clk);
    #1;
    chk("rst ready", ready2, 0);
    chk("rst stall", stall2, 0);
    chk("rst err", err2, 0);
    chk("rst rdata", rdata2, 0);
    reset = 1'b1;
    @(negedge clk);
    access(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, "st_full");
    access(1, 0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEEF, "ld_full");
    access(0, 1, 32'h10, 32'h000000AA, 4'b0001, 0, 32'hDEADBEEF, "st_byte");
    access(1, 0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEAA, "ld_byte");
    access(1, 0, 32'h13, 32'h0, 4'h0, 1, 32'h0, "ld_misal");
    access(1, 0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEAA, "ld_after_misal");
    access(1, 1, 32'h10, 32'h0, 4'hF, 1, 32'h0, "rw_both");
    access(1, 0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEAA, "ld_after_rw");
    access(0, 1, 32'h400, 32'hFFFFFFFF, 4'hF, 1, 32'h0, "st_oor");
    access(1, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0, "ld_word0");
    access(0, 1, 32'h8, 32'hCAFEF00D, 4'h0, 0, 32'h0, "st_noop");
    access(1, 0, 32'h8, 32'h0, 4'h0, 0, 32'h0, "ld_noop");
    access(1, 0, 32'h10, 32'h0, 4'h0, 0, 32'hDEADBEAA, "ld_pre_rst");
    mem_write = 1'b1;
    addr = 32'h20;
    write_data = 32'h12345678;
    byte_en = 4'hF;
    @(negedge clk);
    @(negedge clk);
    mem_write = 1'b0;
    reset = 1'b0;
    #1;
    chk("abort ready", ready2, 0);
    chk("abort stall", stall2, 0);
    chk("abort err", err2, 0);
    chk("abort rdata", rdata2, 0);
    @(negedge clk);
    chk("abort ready_hold", ready2, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("abort ready_after", ready2, 0);
    access(1, 0, 32'h20, 32'h0, 4'h0, 0, 32'h0, "ld_aborted");
    mem_read = 1'b1;
    addr = 32'h10;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("w0 ready c%0d", i), ready0, (i % 2 == 1));
      chk($sformatf("w0 stall c%0d", i), stall0, (i % 2 == 0));
      chk($sformatf("w0 err c%0d", i), err0, 0);
      if (i % 2 == 1) chk($sformatf("w0 rdata c%0d", i), rdata0, 32'hDEADBEAA);
      @(negedge clk);
    end
    mem_read = 1'b0;
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Data-memory responder (slave side) for the RISC_V_FINAL MEM stage.
- Accepts one load or store request at a time from the pipeline, holds the pipeline with mem_stall for a configurable number of wait states, then completes the access and pulses ready.
- Provides the realistic memory-latency end of the pipeline's memory interface, to exercise pipeline_stall behaviour.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in the memory array (power of two).
- WAIT_STATES, 1, extra cycles between request acceptance and the response cycle (0..15).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- mem_read  input  1  load request from the MEM stage.
- mem_write  input  1  store request from the MEM stage.
- addr  input  32  byte address.
- write_data  input  32  store data, little-endian lanes.
- byte_en  input  4  store lane enables; bit i enables write_data[8i+7:8i].
- read_data  output  32  load result; valid in the ready cycle, held until the next response.
- ready  output  1  one-cycle completion pulse.
- mem_stall  output  1  pipeline hold request.
- access_err  output  1  one-cycle error pulse, coincident with ready.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; read_data=0, ready=0, access_err=0, wait counter=0.
  - Memory array is not cleared by reset; it initialises to all zeros at time zero.
- FSM states:
  - IDLE: a request (mem_read|mem_write) latches addr, write_data, byte_en and the operation. The counter is loaded with WAIT_STATES. Next state is WAIT if WAIT_STATES>0, otherwise RESP.
  - WAIT: the counter decrements each cycle. When it reaches 1, the next state is RESP.
  - RESP: ready=1 for this cycle only; next state is IDLE. Request inputs are not sampled in RESP. A back-to-back request is accepted in the following IDLE cycle.
- Latency: request first seen in IDLE at cycle T produces ready at cycle T+WAIT_STATES+1.
- mem_stall (combinational):
  - 1 in IDLE with a request present.
  - 1 throughout WAIT.
  - 0 in RESP, so the pipeline advances on the RESP clock edge.
  - 0 in IDLE with no request.
- Request stability: the pipeline holds its request inputs stable while mem_stall=1. The block uses only the values latched at acceptance.
- Simultaneous mem_read and mem_write: treated as an error access. No memory change; read_data=0; access_err=1 with ready.
- Misaligned address (addr[1:0] != 0): error access with the same effects as above (no change, read_data=0, access_err=1 with ready).
- Out of range (any addr bit above the word-index field nonzero): error access with the same effects.
- Stores:
  - Performed on the clock edge ending RESP.
  - Only enabled byte lanes are updated.
  - byte_en=0 is a legal no-op store (ready pulses, no error).
  - read_data is unchanged by a store.
- Loads: read_data is loaded with the full addressed word on the edge entering RESP and holds until the next completed access.
- Reset asserted mid-access: the access is aborted, no memory write occurs, and no ready is issued.
- Word index = addr[log2(DEPTH_WORDS)+1:2].

Test Plan (WAIT_STATES=2 unless stated):
- Store 0xDEADBEEF, byte_en=4'hF, addr=0x10, first seen at T. Required: mem_stall=1 at T..T+2; ready=1 and mem_stall=0 at T+3. A load from 0x10 issued at T+4 returns read_data=0xDEADBEEF with ready at T+7.
- Byte-lane store 0x000000AA, byte_en=4'b0001, addr=0x10, after the previous test. Required: a subsequent load from 0x10 returns 0xDEADBEAA.
- Misaligned load at addr=0x13. Required: ready and access_err both high at T+3, read_data=0, memory unchanged. The same response is required for mem_read=mem_write=1.
- Out-of-range store to addr=0x0000_0400 with DEPTH_WORDS=256. Required: access_err=1 with ready; a load from 0x0 still returns its prior value.
- reset driven low during WAIT of a store of 0x12345678 to 0x20, then released. Required: all outputs 0 immediately; no ready pulse; a load from 0x20 returns 0x00000000.
- WAIT_STATES=0, back-to-back loads held continuously. Required: ready pulses on alternate cycles (IDLE→RESP→IDLE), mem_stall=1 only in the IDLE cycles.
